apb_top: RTL and testbench
==========================

APB_TOP -- requirements
Module: apb_top

Interface
REQ-001 The module SHALL have input PCLK, 1 bit: the single system clock; all bus and register logic is on its rising edge.
REQ-002 The module SHALL have input PRESETn, 1 bit: reset, asynchronous and active-high (asserted = 1).
REQ-003 The module SHALL have inputs PSEL, PENABLE and PWRITE, 1 bit each: APB select, access phase and write (1) / read (0).
REQ-004 The module SHALL have inputs PADDR and PWDATA, 32 bits each: APB byte address and write data.
REQ-005 The module SHALL have output PRDATA, 32 bits: APB read data.
REQ-006 The module SHALL have output PREADY, 1 bit: APB ready.
REQ-007 The module SHALL have output IRQ, 1 bit: interrupt request.
REQ-008 The module SHALL have input aux_in, 32 bits: auxiliary output sources.
REQ-009 The module SHALL have inout io_pad, 32 bits: bidirectional GPIO pads.
REQ-010 The module SHALL have input ext_clk_pad_i, 1 bit: external sampling clock for inputs.

Function
REQ-011 The register map SHALL be, by exact PADDR match, read/write unless noted:
- 0x00 RGPIO_IN (read-only)
- 0x04 RGPIO_OUT
- 0x08 RGPIO_OE
- 0x0C RGPIO_INTE
- 0x10 RGPIO_PTRIG
- 0x14 RGPIO_AUX
- 0x18 RGPIO_CTRL (2 bits: bit0 INTE, bit1 INTS)
- 0x1C RGPIO_INTS
- 0x20 RGPIO_ECLK
- 0x24 RGPIO_NEC
REQ-012 A write SHALL take effect at the PCLK rising edge where PSEL=1, PENABLE=1 and PWRITE=1; a write to RGPIO_IN or to any unmapped address SHALL be ignored.
REQ-013 PREADY SHALL equal PSEL & PENABLE, giving zero wait states.
REQ-014 PRDATA SHALL be combinational: the selected register (zero-extended) when PSEL=1 and PWRITE=0, otherwise 0; an unmapped address SHALL read 0.
REQ-015 Pad output: io_pad[i] SHALL be driven when RGPIO_OE[i]=1 (1 = output), otherwise high-Z.
REQ-016 The driven value SHALL be aux_in[i] when RGPIO_AUX[i]=1, else RGPIO_OUT[i].
REQ-017 Two external-clock samples of io_pad SHALL be kept: one registered on ext_clk_pad_i rising edge, one on its falling edge.
REQ-018 in_mux[i] SHALL be io_pad[i] when RGPIO_ECLK[i]=0, else the falling-edge sample when RGPIO_NEC[i]=1, else the rising-edge sample.
REQ-019 RGPIO_IN SHALL load in_mux on every PCLK rising edge (1-cycle latency from pad to register).
REQ-020 An interrupt event on bit i SHALL occur when RGPIO_INTE[i]=1, CTRL.INTE=1, and either RGPIO_PTRIG[i]=1 with in_mux[i]=1 and RGPIO_IN[i]=0 (rising), or RGPIO_PTRIG[i]=0 with in_mux[i]=0 and RGPIO_IN[i]=1 (falling).
REQ-021 RGPIO_INTS[i] SHALL set on an event and hold until software writes it.
REQ-022 If a software write to RGPIO_INTS coincides with an event on bit i, bit i SHALL end up set.
REQ-023 CTRL.INTS SHALL be set by hardware in any cycle with at least one event and SHALL be cleared only by a software write to RGPIO_CTRL.
REQ-024 A hardware set of CTRL.INTS SHALL win over a simultaneous CTRL write.
REQ-025 IRQ SHALL equal CTRL.INTS.
REQ-026 Mid-operation reset assertion SHALL abort any transfer immediately.

Reset
REQ-027 While PRESETn=1, all registers, both external-clock sample registers and IRQ SHALL be 0; PRDATA SHALL be 0 and io_pad SHALL be all high-Z.
REQ-028 After PRESETn deasserts, the block SHALL respond from the next PCLK rising edge.

Verification
REQ-029 Write OE=0xFFFFFFFF and OUT=0xAAAAFFFF -> io_pad=0xAAAAFFFF. Then AUX=0xFFFFFFFF with aux_in=0x12345678 -> io_pad=0x12345678; read back OE=0xFFFFFFFF.
REQ-030 OE=0x0000FFFF, OUT=0x0000ABCD, external drive 0xFFFF0000 on the upper half -> RGPIO_IN reads 0xFFFFABCD.
REQ-031 Same setup plus INTE=0xFF000000, PTRIG=0xFF000000, CTRL=01, upper pads 0→1 -> INTS=0xFF000000 and IRQ=1. Then write CTRL=0 -> IRQ=0.
REQ-032 OE=0, ECLK=0xFFFFFFFF, NEC=0xFFFFFFFF, pads driven to 0xAABBCCDD -> RGPIO_IN=0xAABBCCDD only after an ext_clk_pad_i falling edge.
REQ-033 OE=0, PTRIG=INTE=0xFFFFFFFF, CTRL=01, pads 0→0xFFFFFFFF -> INTS=0xFFFFFFFF and IRQ=1. Then write INTS=0 -> reads 0.
REQ-034 Write 0x0 to address 200 (0xC8) -> all registers unchanged and the read of that address returns 0. Separately, assert reset mid-write -> all registers return to 0.

Source files
------------

// File: rtl/apb_top.sv
// APB GPIO block: ten memory-mapped registers, pad drive/sample logic,
// optional external-clock input sampling and edge-triggered interrupts.
module apb_top (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    input  logic [31:0] aux_in,
    inout  wire  [31:0] io_pad,
    input  logic        ext_clk_pad_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;

    localparam logic [AW-1:0] ADDR_IN    = AW'(32'h00);
    localparam logic [AW-1:0] ADDR_OUT   = AW'(32'h04);
    localparam logic [AW-1:0] ADDR_OE    = AW'(32'h08);
    localparam logic [AW-1:0] ADDR_INTE  = AW'(32'h0C);
    localparam logic [AW-1:0] ADDR_PTRIG = AW'(32'h10);
    localparam logic [AW-1:0] ADDR_AUX   = AW'(32'h14);
    localparam logic [AW-1:0] ADDR_CTRL  = AW'(32'h18);
    localparam logic [AW-1:0] ADDR_INTS  = AW'(32'h1C);
    localparam logic [AW-1:0] ADDR_ECLK  = AW'(32'h20);
    localparam logic [AW-1:0] ADDR_NEC   = AW'(32'h24);

    // CTRL bit positions
    localparam int unsigned CTRL_INTE = 0;
    localparam int unsigned CTRL_INTS = 1;

    logic [DW-1:0] in_q,    in_d;
    logic [DW-1:0] out_q,   out_d;
    logic [DW-1:0] oe_q,    oe_d;
    logic [DW-1:0] inte_q,  inte_d;
    logic [DW-1:0] ptrig_q, ptrig_d;
    logic [DW-1:0] aux_q,   aux_d;
    logic [CW-1:0] ctrl_q,  ctrl_d;
    logic [DW-1:0] ints_q,  ints_d;
    logic [DW-1:0] eclk_q,  eclk_d;
    logic [DW-1:0] nec_q,   nec_d;

    logic [DW-1:0] ext_pos_q;
    logic [DW-1:0] ext_neg_q;

    logic          wr_en_c;
    logic [DW-1:0] in_mux_c;
    logic [DW-1:0] event_c;
    logic [DW-1:0] pad_out_c;
    logic [DW-1:0] rd_data_c;

    assign wr_en_c = PSEL & PENABLE & PWRITE;
    assign PREADY  = PSEL & PENABLE;
    assign IRQ     = ctrl_q[CTRL_INTS];

    // Pad output value: auxiliary source or software output register
    assign pad_out_c = (aux_q & aux_in) | (~aux_q & out_q);

    // Tristate pad drivers, one per bit, enabled by OE
    for (genvar g = 0; g < DW; g++) begin : g_pad
        assign io_pad[g] = oe_q[g] ? pad_out_c[g] : 1'bz;
    end

    // Sample pads on the rising edge of the external clock
    always_ff @(posedge ext_clk_pad_i or posedge PRESETn) begin
        if (PRESETn) begin
            ext_pos_q <= '0;
        end else begin
            ext_pos_q <= io_pad;
        end
    end

    // Sample pads on the falling edge of the external clock
    always_ff @(negedge ext_clk_pad_i or posedge PRESETn) begin
        if (PRESETn) begin
            ext_neg_q <= '0;
        end else begin
            ext_neg_q <= io_pad;
        end
    end

    // Per-bit input source: live pad, or one of the external-clock samples
    always_comb begin
        in_mux_c = io_pad;
        for (int i = 0; i < int'(DW); i++) begin
            if (eclk_q[i]) begin
                in_mux_c[i] = nec_q[i] ? ext_neg_q[i] : ext_pos_q[i];
            end
        end
    end

    // Edge detect against the previous input sample, polarity from PTRIG
    always_comb begin
        event_c = '0;
        if (ctrl_q[CTRL_INTE]) begin
            event_c = inte_q & ((ptrig_q & in_mux_c & ~in_q) |
                                (~ptrig_q & ~in_mux_c & in_q));
        end
    end

    // Next-state for all registers: software writes, then hardware sets on top
    always_comb begin
        in_d    = in_mux_c;
        out_d   = out_q;
        oe_d    = oe_q;
        inte_d  = inte_q;
        ptrig_d = ptrig_q;
        aux_d   = aux_q;
        ctrl_d  = ctrl_q;
        ints_d  = ints_q;
        eclk_d  = eclk_q;
        nec_d   = nec_q;

        if (wr_en_c) begin
            case (PADDR)
                ADDR_OUT:   out_d   = PWDATA;
                ADDR_OE:    oe_d    = PWDATA;
                ADDR_INTE:  inte_d  = PWDATA;
                ADDR_PTRIG: ptrig_d = PWDATA;
                ADDR_AUX:   aux_d   = PWDATA;
                ADDR_CTRL:  ctrl_d  = PWDATA[CW-1:0];
                ADDR_INTS:  ints_d  = PWDATA;
                ADDR_ECLK:  eclk_d  = PWDATA;
                ADDR_NEC:   nec_d   = PWDATA;
                default:    ;
            endcase
        end

        // Hardware events override a coincident software write
        ints_d = ints_d | event_c;
        if (|event_c) begin
            ctrl_d[CTRL_INTS] = 1'b1;
        end
    end

    // Register bank
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            in_q    <= '0;
            out_q   <= '0;
            oe_q    <= '0;
            inte_q  <= '0;
            ptrig_q <= '0;
            aux_q   <= '0;
            ctrl_q  <= '0;
            ints_q  <= '0;
            eclk_q  <= '0;
            nec_q   <= '0;
        end else begin
            in_q    <= in_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            inte_q  <= inte_d;
            ptrig_q <= ptrig_d;
            aux_q   <= aux_d;
            ctrl_q  <= ctrl_d;
            ints_q  <= ints_d;
            eclk_q  <= eclk_d;
            nec_q   <= nec_d;
        end
    end

    // Read mux; unmapped addresses and non-read cycles return zero
    always_comb begin
        rd_data_c = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_IN:    rd_data_c = in_q;
                ADDR_OUT:   rd_data_c = out_q;
                ADDR_OE:    rd_data_c = oe_q;
                ADDR_INTE:  rd_data_c = inte_q;
                ADDR_PTRIG: rd_data_c = ptrig_q;
                ADDR_AUX:   rd_data_c = aux_q;
                ADDR_CTRL:  rd_data_c = DW'(ctrl_q);
                ADDR_INTS:  rd_data_c = ints_q;
                ADDR_ECLK:  rd_data_c = eclk_q;
                ADDR_NEC:   rd_data_c = nec_q;
                default:    rd_data_c = '0;
            endcase
        end
    end

    assign PRDATA = rd_data_c;

endmodule

// File: tb/tb_apb_top.sv
// Self-checking bench for apb_top: directed GPIO scenarios plus a short
// randomized register/pad pass, with expected values queued in a scoreboard.
module tb_apb_top;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        IRQ;
    logic [31:0] aux_in;
    wire  [31:0] io_pad;
    logic        ext_clk;

    logic [31:0] ext_en;
    logic [31:0] ext_val;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    // model of the plain read/write registers used by the random pass
    logic [31:0] m_reg[7];
    logic [31:0] m_addr[7];

    apb_top dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .IRQ           (IRQ),
        .aux_in        (aux_in),
        .io_pad        (io_pad),
        .ext_clk_pad_i (ext_clk)
    );

    // external pad drivers
    for (genvar g = 0; g < 32; g++) begin : g_ext
        assign io_pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_cmp(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %h with empty scoreboard", tag, got);
        end else begin
            check_val(tag, got, exp_q.pop_front());
        end
    endtask

    // APB write; optionally changes the external pad value during the access phase
    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic flip, input logic [31:0] pv);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (flip) ext_val = pv;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb_wr(a, d, 1'b0, 32'h0);
    endtask

    // APB read with expected data queued before the transfer starts
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] got;
        logic        rdy;
        sb_push(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        got = PRDATA;
        rdy = PREADY;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (rdy !== 1'b1) check_val({tag, "_pready"}, 32'(rdy), 32'h1);
        sb_cmp(tag, got);
    endtask

    // Compare a directly observed value through the scoreboard
    task automatic obs_chk(input string tag, input logic [31:0] got, input logic [31:0] e);
        sb_push(e);
        sb_cmp(tag, got);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pad;

        m_addr[0] = 32'h04; m_addr[1] = 32'h08; m_addr[2] = 32'h0C;
        m_addr[3] = 32'h10; m_addr[4] = 32'h14; m_addr[5] = 32'h20;
        m_addr[6] = 32'h24;

        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; aux_in = '0; ext_clk = 1'b0;
        ext_en = '0; ext_val = '0;
        PRESETn = 1'b0;
        #1 PRESETn = 1'b1;

        // reset state, observed while reset is held
        wait_clk(2);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h18;
        #1;
        obs_chk("rst_irq", 32'(IRQ), 32'h0);
        obs_chk("rst_prdata", PRDATA, 32'h0);
        PSEL = 1'b0;
        #3 PRESETn = 1'b0;

        rd_chk("rst_out", 32'h04, 32'h0);
        rd_chk("rst_oe", 32'h08, 32'h0);
        rd_chk("rst_ctrl", 32'h18, 32'h0);
        rd_chk("rst_ints", 32'h1C, 32'h0);

        // output drive, then auxiliary source
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h04, 32'hAAAA_FFFF);
        obs_chk("pad_out", io_pad, 32'hAAAA_FFFF);
        aux_in = 32'h1234_5678;
        wr(32'h14, 32'hFFFF_FFFF);
        obs_chk("pad_aux", io_pad, 32'h1234_5678);
        rd_chk("oe_rb", 32'h08, 32'hFFFF_FFFF);
        wr(32'h14, 32'h0);

        // mixed direction: lower half driven by DUT, upper half external
        wr(32'h08, 32'h0000_FFFF);
        wr(32'h04, 32'h0000_ABCD);
        ext_en = 32'hFFFF_0000; ext_val = 32'hFFFF_0000;
        wait_clk(2);
        rd_chk("in_mixed", 32'h00, 32'hFFFF_ABCD);

        // rising-edge interrupts on the top byte
        ext_val = 32'h0;
        wait_clk(2);
        wr(32'h0C, 32'hFF00_0000);
        wr(32'h10, 32'hFF00_0000);
        wr(32'h18, 32'h1);
        obs_chk("irq_idle", 32'(IRQ), 32'h0);
        ext_val = 32'hFFFF_0000;
        wait_clk(2);
        rd_chk("ints_rise", 32'h1C, 32'hFF00_0000);
        obs_chk("irq_set", 32'(IRQ), 32'h1);
        wr(32'h18, 32'h0);
        obs_chk("irq_clr", 32'(IRQ), 32'h0);

        // software writes coinciding with hardware events
        wr(32'h08, 32'h0);
        ext_en = 32'hFFFF_FFFF; ext_val = 32'h0;
        wait_clk(1);
        wr(32'h1C, 32'h0);
        wr(32'h0C, 32'h3);
        wr(32'h10, 32'h3);
        wr(32'h18, 32'h1);
        apb_wr(32'h1C, 32'h0, 1'b1, 32'h1);
        rd_chk("ints_wr_race", 32'h1C, 32'h1);
        apb_wr(32'h18, 32'h1, 1'b1, 32'h3);
        rd_chk("ctrl_wr_race", 32'h18, 32'h3);
        rd_chk("ints_race2", 32'h1C, 32'h3);

        // all-bit rising interrupts, then clear INTS
        wr(32'h18, 32'h0);
        wr(32'h1C, 32'h0);
        ext_val = 32'h0;
        wait_clk(2);
        wr(32'h10, 32'hFFFF_FFFF);
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h18, 32'h1);
        ext_val = 32'hFFFF_FFFF;
        wait_clk(2);
        rd_chk("ints_all", 32'h1C, 32'hFFFF_FFFF);
        obs_chk("irq_all", 32'(IRQ), 32'h1);
        wr(32'h1C, 32'h0);
        rd_chk("ints_cleared", 32'h1C, 32'h0);

        // external clock sampling on the falling edge
        wr(32'h18, 32'h0);
        wr(32'h0C, 32'h0);
        wr(32'h20, 32'hFFFF_FFFF);
        wr(32'h24, 32'hFFFF_FFFF);
        ext_val = 32'hAABB_CCDD;
        wait_clk(2);
        rd_chk("eclk_pre", 32'h00, 32'h0);
        ext_clk = 1'b1;
        wait_clk(2);
        rd_chk("eclk_rise_only", 32'h00, 32'h0);
        ext_clk = 1'b0;
        wait_clk(2);
        rd_chk("eclk_fall", 32'h00, 32'hAABB_CCDD);
        wr(32'h24, 32'h0);
        ext_val = 32'h0;
        wait_clk(2);
        rd_chk("eclk_pos_sel", 32'h00, 32'hAABB_CCDD);

        // randomized register and pad pass
        ext_en = '0;
        for (int it = 0; it < 3; it++) begin
            aux_in = $urandom;
            for (int r = 0; r < 7; r++) begin
                m_reg[r] = $urandom;
                wr(m_addr[r], m_reg[r]);
            end
            for (int r = 0; r < 7; r++) begin
                rd_chk($sformatf("rand_rb%0d_%0d", it, r), m_addr[r], m_reg[r]);
            end
            exp_pad = ((m_reg[4] & aux_in) | (~m_reg[4] & m_reg[0])) & m_reg[1];
            obs_chk($sformatf("rand_pad%0d", it), io_pad & m_reg[1], exp_pad);
        end

        // unmapped write is ignored and reads zero
        wr(32'hC8, 32'h0);
        rd_chk("unmapped_rd", 32'hC8, 32'h0);
        for (int r = 0; r < 7; r++) begin
            rd_chk($sformatf("unmapped_keep%0d", r), m_addr[r], m_reg[r]);
        end

        // reset asserted during the access phase of a write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 32'h04; PWDATA = 32'h5555_5555;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESETn = 1'b1;
        #1;
        obs_chk("midrst_irq", 32'(IRQ), 32'h0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        ext_en = 32'hFFFF_FFFF; ext_val = 32'h0;
        wait_clk(1);
        #2 PRESETn = 1'b0;
        wait_clk(1);
        rd_chk("midrst_in", 32'h00, 32'h0);
        for (int r = 0; r < 7; r++) begin
            rd_chk($sformatf("midrst_reg%0d", r), m_addr[r], 32'h0);
        end
        rd_chk("midrst_ctrl", 32'h18, 32'h0);
        rd_chk("midrst_ints", 32'h1C, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
